// File: rtl/fir_pkg.sv
// Shared types, constants and sizing helpers for the parallel FIR slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

  // Default widths of the audio path; the datapath modules take their
  // own parameters, these typedefs describe the standard build.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_ACC_W  = 64;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  // Input block to output block, in clock cycles.
  localparam int LATENCY = 2;

  // Registered samples needed to cover the full tap span behind a block.
  function automatic int hist_depth(input int taps);
    return taps - 1;
  endfunction

  // Coefficient address width; a single-tap filter still gets a 1-bit address.
  function automatic int addr_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/parallel_fir_lx_if.sv
// Sample stream bundle between the deserialiser, the FIR and the requantiser.
// Latency: n/a (wires only).
// Backpressure: none; valid-only stream with gaps allowed.
//   in_valid/d_phase : input block, phase 0 is the oldest sample
//   flush            : clear history and in-flight results
//   out_valid/out_phase : filtered block, phase-aligned with d_phase
interface parallel_fir_lx_if #(
  parameter int PARALLEL = 3,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 64
);
  logic                         in_valid;
  logic [PARALLEL*DATA_W-1:0]   d_phase;
  logic                         flush;
  logic                         out_valid;
  logic [PARALLEL*ACC_W-1:0]    out_phase;

  modport master (
    output in_valid, d_phase, flush,
    input  out_valid, out_phase
  );

  modport slave (
    input  in_valid, d_phase, flush,
    output out_valid, out_phase
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient store: writes go to the shadow bank, a swap
// pulse makes the shadow active. Latency: write/swap take effect at the edge.
// Backpressure: none.
//   clk, rst (sync, active-low) | coef_we/coef_addr/coef_data : shadow write
//   coef_swap : toggle active bank | active_bank : current bank index
//   coef_flat : active coefficients, tap i at [i*COEF_W +: COEF_W]
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int  TAPS   = 32,
  parameter int  COEF_W = 16,
  localparam int ADDR_W = addr_width(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     coef_swap,
  output logic                     active_bank,
  output logic [TAPS*COEF_W-1:0]   coef_flat
);

  logic [COEF_W-1:0] bank0 [TAPS];
  logic [COEF_W-1:0] bank1 [TAPS];
  logic              act;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      act <= 1'b0;
    end else begin
      // The shadow is chosen from the pre-swap bank, so a write in the
      // swap cycle lands in the bank that is about to go live.
      if (coef_we && (int'(coef_addr) < TAPS)) begin
        if (act) bank0[coef_addr] <= coef_data;
        else     bank1[coef_addr] <= coef_data;
      end
      if (coef_swap) act <= ~act;
    end
  end

  always_comb begin
    coef_flat = '0;
    for (int i = 0; i < TAPS; i++) begin
      coef_flat[i*COEF_W +: COEF_W] = act ? bank1[i] : bank0[i];
    end
  end

  assign active_bank = act;

endmodule

// File: rtl/parallel_fir_lx.sv
// L-parallel direct-form FIR: PARALLEL samples in, PARALLEL exact outputs out.
// Latency: 2 cycles (stage 1 window/coef snapshot, stage 2 MAC + output reg).
// Backpressure: none; out_valid is in_valid delayed by 2, flush drops in-flight.
//   clk, rst (sync, active-low) | bus : sample stream (slave side)
//   coef_we/coef_addr/coef_data/coef_swap : coefficient shadow write and swap
//   active_bank : coefficient bank currently feeding the datapath
module parallel_fir_lx
  import fir_pkg::*;
#(
  parameter int  PARALLEL = 3,
  parameter int  TAPS     = 32,
  parameter int  DATA_W   = 16,
  parameter int  COEF_W   = 16,
  parameter int  ACC_W    = 64,
  localparam int ADDR_W   = addr_width(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  parallel_fir_lx_if.slave     bus,
  input  logic                 coef_we,
  input  logic [ADDR_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0]    coef_data,
  input  logic                 coef_swap,
  output logic                 active_bank
);

  localparam int HD  = hist_depth(TAPS);
  localparam int HS  = (HD > 0) ? HD : 1;
  localparam int SEQ = TAPS + PARALLEL - 1;
  localparam int PW  = DATA_W + COEF_W;

  logic [TAPS*COEF_W-1:0]   coef_flat;
  logic [TAPS*COEF_W-1:0]   s1_coef;
  logic signed [DATA_W-1:0] hist   [HS];
  logic signed [DATA_W-1:0] seq    [SEQ];
  logic signed [DATA_W-1:0] s1_seq [SEQ];
  logic                     s1_vld;
  logic signed [ACC_W-1:0]  sum    [PARALLEL];
  logic [PARALLEL*ACC_W-1:0] out_q;
  logic                     out_vld_q;
  logic signed [COEF_W-1:0] c;
  logic signed [PW-1:0]     prod;

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clk         (clk),
    .rst         (rst),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_swap   (coef_swap),
    .active_bank (active_bank),
    .coef_flat   (coef_flat)
  );

  // Sample window ordered by age: seq[0] is the newest sample (last phase of
  // the incoming block), followed by the registered history.
  always_comb begin
    for (int a = 0; a < SEQ; a++) begin
      if (a < PARALLEL) seq[a] = bus.d_phase[(PARALLEL-1-a)*DATA_W +: DATA_W];
      else              seq[a] = hist[a-PARALLEL];
    end
  end

  // Stage 1: history shift and window/coefficient snapshot. The snapshot is
  // taken from the bank that is active before any swap at this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < HS; j++)  hist[j]   <= '0;
      for (int a = 0; a < SEQ; a++) s1_seq[a] <= '0;
      s1_coef <= '0;
      s1_vld  <= 1'b0;
    end else if (bus.flush) begin
      for (int j = 0; j < HS; j++) hist[j] <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        for (int j = 0; j < HD; j++)  hist[j]   <= seq[j];
        for (int a = 0; a < SEQ; a++) s1_seq[a] <= seq[a];
        s1_coef <= coef_flat;
      end
    end
  end

  // Stage 2 arithmetic: phase p sits at age PARALLEL-1-p, so tap i reads the
  // sample i positions older. Products fit PW bits exactly, then sign-extend.
  always_comb begin
    c    = '0;
    prod = '0;
    for (int p = 0; p < PARALLEL; p++) begin
      sum[p] = '0;
      for (int i = 0; i < TAPS; i++) begin
        c      = s1_coef[i*COEF_W +: COEF_W];
        prod   = PW'(s1_seq[PARALLEL-1-p+i]) * PW'(c);
        sum[p] = sum[p] + ACC_W'(prod);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (bus.flush) begin
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= s1_vld;
      if (s1_vld) begin
        for (int p = 0; p < PARALLEL; p++) out_q[p*ACC_W +: ACC_W] <= sum[p];
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_phase = out_q;

endmodule

// File: tb/tb_parallel_fir_lx.sv
`timescale 1ns/1ps
module tb_parallel_fir_lx;
  import fir_pkg::*;

  localparam int P  = 3;
  localparam int T  = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 64;

  typedef logic [P-1:0][DW-1:0] blk_t;
  typedef logic [P-1:0][AW-1:0] oblk_t;
  typedef struct packed { oblk_t y; int due; } exp_t;
  typedef struct packed { blk_t blk; oblk_t exp; } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          coef_we;
  logic [2:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic          coef_swap;
  logic          active_bank;

  parallel_fir_lx_if #(.PARALLEL(P), .DATA_W(DW), .ACC_W(AW)) bus();

  parallel_fir_lx #(
    .PARALLEL(P), .TAPS(T), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_swap   (coef_swap),
    .active_bank (active_bank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  exp_t   sbq[$];
  longint mh[2][T];
  int     mact = 0;
  longint xs[$];
  vec_t   tbl[4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drop_inflight();
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].due > cyc) sbq.delete(i);
  endtask

  // One clock: drive inputs, advance the reference model to match the
  // coming edge, then wait for the edge. ovr pushes a hand-derived result.
  task automatic tick(input logic v, input blk_t blk, input logic fl,
                      input logic we, input int addr, input longint cval,
                      input logic sw, input logic ovr, input oblk_t oexp);
    oblk_t  e;
    exp_t   ent;
    longint acc;
    int     n;
    bus.in_valid = v;
    bus.d_phase  = blk;
    bus.flush    = fl;
    coef_we      = we;
    coef_addr    = 3'(addr);
    coef_data    = CW'(cval);
    coef_swap    = sw;
    e = '0;
    if (fl) begin
      xs.delete();
      drop_inflight();
    end else if (v) begin
      for (int p = 0; p < P; p++) begin
        xs.push_back(longint'($signed(blk[p])));
        n   = xs.size() - 1;
        acc = 0;
        for (int i = 0; i < T; i++)
          if (n - i >= 0) acc += mh[mact][i] * xs[n-i];
        e[p] = acc;
      end
      while (xs.size() > T) void'(xs.pop_front());
      ent.y   = ovr ? oexp : e;
      ent.due = cyc + LATENCY;
      sbq.push_back(ent);
    end
    if (we && addr < T) mh[1-mact][addr] = longint'($signed(CW'(cval)));
    if (sw) mact = 1 - mact;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(0, '0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic send(input blk_t b);
    tick(1, b, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic wr(input int a, input longint v);
    tick(0, '0, 0, 1, a, v, 0, 0, '0);
  endtask

  task automatic load_and_swap(input longint base, input longint step);
    for (int i = 0; i < T; i++) wr(i, base + step * i);
    tick(0, '0, 0, 0, 0, 0, 1, 0, '0);
  endtask

  function automatic blk_t fill(input int v);
    blk_t b;
    for (int p = 0; p < P; p++) b[p] = DW'(v);
    return b;
  endfunction

  function automatic oblk_t ofill(input longint v);
    oblk_t o;
    for (int p = 0; p < P; p++) o[p] = v;
    return o;
  endfunction

  // Scoreboard: every valid output must match the oldest pending entry,
  // arrive exactly on its due cycle, and no entry may be skipped.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_output: due cycle %0d, still absent at cycle %0d", sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output at cycle %0d: got %h", cyc, bus.out_phase);
      end else begin
        e = sbq.pop_front();
        if (e.due != cyc || e.y != bus.out_phase) begin
          errors++;
          $display("FAIL output_block cycle %0d (due %0d): got %0d %0d %0d expected %0d %0d %0d",
                   cyc, e.due,
                   $signed(bus.out_phase[0*AW +: AW]), $signed(bus.out_phase[1*AW +: AW]),
                   $signed(bus.out_phase[2*AW +: AW]),
                   $signed(e.y[0]), $signed(e.y[1]), $signed(e.y[2]));
        end
      end
    end
  end

  initial begin
    blk_t b;
    tbl[0].blk = {16'sd0, 16'sd0, 16'sd1};  tbl[0].exp = {64'sd3, 64'sd2, 64'sd1};
    tbl[1].blk = {16'sd0, 16'sd0, 16'sd0};  tbl[1].exp = {64'sd6, 64'sd5, 64'sd4};
    tbl[2].blk = {16'sd0, 16'sd0, 16'sd0};  tbl[2].exp = {64'sd0, 64'sd8, 64'sd7};
    tbl[3].blk = {16'sd0, 16'sd0, 16'sd0};  tbl[3].exp = {64'sd0, 64'sd0, 64'sd0};
    for (int k = 0; k < 2; k++) for (int i = 0; i < T; i++) mh[k][i] = 0;

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.d_phase = '0; bus.flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_out_phase_zero", longint'(bus.out_phase == '0), 1);
    chk("reset_active_bank", longint'(active_bank), 0);
    rst = 1'b1;

    // Impulse response with h = 1..8 loaded into the shadow and swapped in.
    load_and_swap(1, 1);
    chk("swap_active_bank", longint'(active_bank), 1);
    for (int i = 0; i < 4; i++) tick(1, tbl[i].blk, 0, 0, 0, 0, 0, 1, tbl[i].exp);
    idle(3);

    // Same impulse with gaps in in_valid: 1,0,0,1,0,1,0,0,...
    tick(0, '0, 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      tick(1, tbl[i].blk, 0, 0, 0, 0, 0, 1, tbl[i].exp);
      idle((i % 2 == 0) ? 2 : 1);
    end
    idle(3);

    // DC response settles at the coefficient sum.
    tick(0, '0, 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) send(fill(1));
    idle(3);
    for (int p = 0; p < P; p++) chk("dc_steady_36", $signed(bus.out_phase[p*AW +: AW]), 36);

    // Swap on an accepted block: that block uses the old bank, the next the new.
    for (int i = 0; i < T; i++) wr(i, 2);
    send(fill(1));
    tick(1, fill(1), 0, 0, 0, 0, 1, 1, ofill(36));
    tick(1, fill(1), 0, 0, 0, 0, 0, 1, ofill(16));
    idle(3);
    chk("boundary_swap_bank", longint'(active_bank), 0);

    // Write and swap in the same cycle, then back-to-back swaps.
    tick(0, '0, 0, 1, 0, 5, 1, 0, '0);
    tick(0, '0, 0, 0, 0, 0, 1, 0, '0);
    chk("toggle_bank_a", longint'(active_bank), 0);
    tick(0, '0, 0, 0, 0, 0, 1, 0, '0);
    chk("toggle_bank_b", longint'(active_bank), 1);
    for (int i = 0; i < 4; i++) send(fill(1));
    idle(2);
    for (int p = 0; p < P; p++) chk("write_with_swap_40", $signed(bus.out_phase[p*AW +: AW]), 40);

    // Full-scale negative samples and coefficients: exact +2^33, no wrap.
    load_and_swap(-32768, 0);
    tick(0, '0, 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) send(fill(-32768));
    idle(3);
    for (int p = 0; p < P; p++) chk("extreme_2pow33", $signed(bus.out_phase[p*AW +: AW]), 64'sd8589934592);

    // Flush mid-stream (with a dropped block) must leave no stale tail.
    load_and_swap(1, 1);
    for (int i = 0; i < 3; i++) send(fill(i * 7 - 9));
    tick(1, fill(99), 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) tick(1, tbl[i].blk, 0, 0, 0, 0, 0, 1, tbl[i].exp);
    idle(3);

    // Random traffic against the reference model.
    for (int k = 0; k < 200; k++) begin
      for (int p = 0; p < P; p++) b[p] = DW'(int'($urandom_range(0, 400)) - 200);
      tick(1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 5) == 0), int'($urandom_range(0, T - 1)),
           longint'(int'($urandom_range(0, 200)) - 100),
           1'($urandom_range(0, 15) == 0), 0, '0);
    end
    idle(3);

    // One-cycle reset mid-stream: in-flight blocks and coefficients are lost.
    send(fill(3));
    send(fill(3));
    rst = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) for (int i = 0; i < T; i++) mh[k][i] = 0;
    mact = 0;
    xs.delete();
    drop_inflight();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    chk("midreset_out_valid", longint'(bus.out_valid), 0);
    chk("midreset_out_phase_zero", longint'(bus.out_phase == '0), 1);
    chk("midreset_active_bank", longint'(active_bank), 0);
    tick(1, fill(5), 0, 0, 0, 0, 0, 1, ofill(0));
    tick(0, '0, 0, 0, 0, 0, 1, 0, '0);
    tick(1, fill(5), 0, 0, 0, 0, 0, 1, ofill(0));
    idle(3);

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
